// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  localparam int GCD_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers and subtract/compare logic for the GCD engine.
// load captures a new operand pair; x_sel/y_sel pick the difference and x_en/y_en enable the write.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             x_sel,
  input  logic             y_sel,
  input  logic             x_en,
  input  logic             y_en,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] x_val,
  output logic [WIDTH-1:0] y_val,
  output logic             x_lt_y,
  output logic             x_gt_y,
  output logic             x_eq_y,
  output logic             x_zero,
  output logic             y_zero
);

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;

  // Load mux and subtractors; a subtraction is only selected when its minuend is larger.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load) begin
      x_d = a_in;
      y_d = b_in;
    end else begin
      x_d = x_sel ? (x_q - y_q) : x_q;
      y_d = y_sel ? (y_q - x_q) : y_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= {WIDTH{1'b0}};
      y_q <= {WIDTH{1'b0}};
    end else begin
      if (x_en) begin
        x_q <= x_d;
      end else begin
        x_q <= x_q;
      end
      if (y_en) begin
        y_q <= y_d;
      end else begin
        y_q <= y_q;
      end
    end
  end

  assign x_val  = x_q;
  assign y_val  = y_q;
  assign x_lt_y = (x_q < y_q);
  assign x_gt_y = (x_q > y_q);
  assign x_eq_y = (x_q == y_q);
  assign x_zero = (x_q == {WIDTH{1'b0}});
  assign y_zero = (y_q == {WIDTH{1'b0}});

endmodule

// File: rtl/gcd_unit.sv
// Handshaked GCD engine: Euclid by repeated subtraction, one step per cycle.
// Define GCD_ITER_CNT_EN to add the iter_cnt output (subtraction count of the last operation).
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic             zero_flag,
  output logic             busy
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [WIDTH-1:0] iter_cnt
`endif
);

  gcd_state_e state_q, state_d;

  logic             load_s, sub_x_s, sub_y_s, done_set_s, valid_d;
  logic [WIDTH-1:0] x_val, y_val, res_s;
  logic             x_lt_y, x_gt_y, x_eq_y, x_zero, y_zero;
  logic [WIDTH-1:0] gcd_q;
  logic             zero_q, valid_q;

  gcd_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_s),
    .x_sel  (sub_x_s),
    .y_sel  (sub_y_s),
    .x_en   (load_s | sub_x_s),
    .y_en   (load_s | sub_y_s),
    .a_in   (a_in),
    .b_in   (b_in),
    .x_val  (x_val),
    .y_val  (y_val),
    .x_lt_y (x_lt_y),
    .x_gt_y (x_gt_y),
    .x_eq_y (x_eq_y),
    .x_zero (x_zero),
    .y_zero (y_zero)
  );

  // Next-state and datapath control; terminal checks take priority over subtraction.
  always_comb begin
    state_d    = state_q;
    load_s     = 1'b0;
    sub_x_s    = 1'b0;
    sub_y_s    = 1'b0;
    done_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_s  = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (x_zero || y_zero || x_eq_y) begin
          done_set_s = 1'b1;
          state_d    = DONE;
        end else if (x_gt_y) begin
          sub_x_s = 1'b1;
        end else if (x_lt_y) begin
          sub_y_s = 1'b1;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With x == 0 the answer is y; in every other terminal case it is x.
  assign res_s   = x_zero ? y_val : x_val;
  assign valid_d = (state_d == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gcd_q   <= {WIDTH{1'b0}};
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (done_set_s) begin
        gcd_q  <= res_s;
        zero_q <= x_zero && y_zero;
      end else begin
        gcd_q  <= gcd_q;
        zero_q <= zero_q;
      end
    end
  end

`ifdef GCD_ITER_CNT_EN
  logic [WIDTH-1:0] cnt_q;

  // Cleared on accept, bumped on every subtraction, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {WIDTH{1'b0}};
    end else if (load_s) begin
      cnt_q <= {WIDTH{1'b0}};
    end else if (sub_x_s || sub_y_s) begin
      cnt_q <= cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign iter_cnt = cnt_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign gcd_out   = gcd_q;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_gcd_unit.sv
// Scoreboard bench for gcd_unit: the driver queues expected results, a negedge monitor checks them.
module tb_gcd_unit;

  localparam int W = 16;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a_in      = '0;
  logic [W-1:0] b_in      = '0;
  logic         in_ready, out_valid, zero_flag, busy;
  logic [W-1:0] gcd_out;
`ifdef GCD_ITER_CNT_EN
  logic [W-1:0] iter_cnt;
`endif

  gcd_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gcd_out   (gcd_out),
    .zero_flag (zero_flag),
    .busy      (busy)
`ifdef GCD_ITER_CNT_EN
    ,
    .iter_cnt  (iter_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int g;
    int z;
    int n;
    int acc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic rand_rdy  = 1'b0;
  logic rdy_force = 1'b1;

  // out_ready moves shortly after the rising edge so it is stable at the monitor's negedge
  always @(posedge clk) begin
    #2;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    else          out_ready = rdy_force;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int   rise_cyc = 0;
  logic prev_v   = 1'b0;

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    int   lat;
    exp_t e;
    if (!rst_n) begin
      prev_v <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        lat = prev_v ? rise_cyc : cyc;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got gcd_out %0d expected no output", gcd_out);
        end else begin
          e = sbq.pop_front();
          check("gcd_out", gcd_out, e.g);
          check("zero_flag", zero_flag, e.z);
          check("latency", lat - e.acc + 1, e.n + 2);
`ifdef GCD_ITER_CNT_EN
          check("iter_cnt", iter_cnt, e.n);
`endif
        end
      end
      if (out_valid && !prev_v) rise_cyc <= cyc;
      prev_v <= out_valid;
    end
  end

  // Independent reference: Euclid by division; subtraction count is sum of quotients minus one
  function automatic void ref_gcd(input int a, input int b, output int g, output int n);
    int x, y, r;
    x = a; y = b; n = 0;
    if (x == 0 || y == 0) begin
      g = x + y;
    end else begin
      while (y != 0) begin
        n += x / y;
        r  = x % y;
        x  = y;
        y  = r;
      end
      g = x;
      n = n - 1;
    end
  endfunction

  task automatic issue(input int a, input int b, input int g, input int z, input int n, input bit push);
    int waitc;
    waitc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = a[W-1:0];
    b_in     = b[W-1:0];
    while (!in_ready && waitc < 3000) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 for (%0d,%0d)", a, b);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (push) sbq.push_back('{g, z, n, cyc});
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sbq.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", sbq.size(), 0);
  endtask

  initial begin
    int g, n, a, b, t;

    // Reset state, observed while rst_n is still low
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_gcd_out", gcd_out, 0);
    check("rst_zero_flag", zero_flag, 0);
`ifdef GCD_ITER_CNT_EN
    check("rst_iter_cnt", iter_cnt, 0);
`endif
    rst_n = 1'b1;

    // Directed vectors with hand-computed gcd / zero_flag / subtraction count
    issue(12, 8, 4, 0, 2, 1'b1);
    drain();
    issue(7, 7, 7, 0, 0, 1'b1);
    issue(0, 9, 9, 0, 0, 1'b1);
    issue(9, 0, 9, 0, 0, 1'b1);
    issue(0, 0, 0, 1, 0, 1'b1);
    issue(65535, 65535, 65535, 0, 0, 1'b1);
    issue(40000, 30000, 10000, 0, 3, 1'b1);
    issue(255, 1, 1, 0, 254, 1'b1);
    drain();

    // Consumer stall in DONE with a competing in_valid
    rdy_force = 1'b0;
    issue(48, 18, 6, 0, 4, 1'b1);
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("stall_reached_done", out_valid, 1);
    in_valid = 1'b1;
    a_in     = 16'd5;
    b_in     = 16'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_gcd_out", gcd_out, 6);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    rdy_force = 1'b1;
    repeat (2) @(negedge clk);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_busy", busy, 0);
    check("post_hs_queue", sbq.size(), 0);

    // Reset during CALC discards the operation
    issue(1000, 3, 1, 0, 0, 1'b0);
    repeat (4) @(negedge clk);
    check("midcalc_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_gcd_out", gcd_out, 0);
    issue(21, 14, 7, 0, 2, 1'b1);
    drain();

    // Random pairs against the reference, with random gaps and consumer back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(0, 300);
      b = $urandom_range(0, 300);
      ref_gcd(a, b, g, n);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(a, b, g, (a == 0 && b == 0) ? 1 : 0, n, 1'b1);
    end
    drain();
    rand_rdy = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
